gpr_wb_arbiter: RTL and testbench

- Shares the register file's single write port among N_REQ writeback requesters: pipeline ALU/load writeback, jal link to $31, the overflow flag to $30, and the mult/div result.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write and drives the register-file write port with it.
- Forwards that in-flight write onto two read ports, so readers see the value before the register file commits it. This replaces ad-hoc multi-driver writes to $30/$31.

---
 rtl/gpr_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/gpr_wb_arbiter.sv | 105 ++++++++++
 tb/tb_gpr_wb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared register-file constants and requester identities for the GPR writeback path.
package gpr_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_FLAG = 5'd30;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        REQ_WB   = 2'd0,
        REQ_LINK = 2'd1,
        REQ_FLAG = 2'd2,
        REQ_MDU  = 2'd3
    } req_id_e;

    // $0 reads are hardwired, so an in-flight write to it must never be forwarded.
    function automatic logic fwd_hit(input logic                  wen,
                                     input logic [REG_ADDR_W-1:0] waddr,
                                     input logic [REG_ADDR_W-1:0] raddr);
        return wen && (waddr == raddr) && (raddr != REG_ZERO);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, cyclically.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        int   j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (en_i && !found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin owner of the register-file write port, with the registered write
// forwarded onto both read ports until the register file commits it.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arb_en,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [REG_ADDR_W*N_REQ-1:0]  req_addr,
    input  logic [DATA_W*N_REQ-1:0]      req_data,
    output logic                         wr_en,
    output logic [REG_ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    input  logic [REG_ADDR_W-1:0]        rd_addr_1,
    input  logic [REG_ADDR_W-1:0]        rd_addr_2,
    input  logic [DATA_W-1:0]            gpr_data_1,
    input  logic [DATA_W-1:0]            gpr_data_2,
    output logic [DATA_W-1:0]            rd_data_1,
    output logic [DATA_W-1:0]            rd_data_2,
    output logic [CNT_W-1:0]             conflict_cnt
);

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]      gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0]     win_data;

    logic                  wr_en_q,   wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    logic [IW-1:0]         rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Grants are masked while reset is held so no requester sees a phantom handshake.
    assign req_ready = gnt & {N_REQ{reset}};
    assign xfer      = |(req_valid & req_ready);
    assign win_addr  = req_addr[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign win_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
            if (win_addr != REG_ZERO) begin
                wr_en_d   = 1'b1;
                wr_addr_d = win_addr;
                wr_data_d = win_data;
            end
        end
        cnt_d = cnt_q;
        if (arb_en && ($countones(req_valid) > 1) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign conflict_cnt = cnt_q;

    assign rd_data_1 = fwd_hit(wr_en_q, wr_addr_q, rd_addr_1) ? wr_data_q : gpr_data_1;
    assign rd_data_2 = fwd_hit(wr_en_q, wr_addr_q, rd_addr_2) ? wr_data_q : gpr_data_2;

    // A requester may not withdraw a pending write before it has been accepted.
    for (genvar i = 0; i < N_REQ; i++) begin : g_hold_chk
        a_valid_hold: assert property (@(posedge clk) disable iff (!reset)
            (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Randomized and directed bench for gpr_wb_arbiter: a queue-based fairness model feeds
// a write scoreboard that a separate monitor drains against the register-file port.
module tb_gpr_wb_arbiter;
    import gpr_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 3;

    logic            clk = 1'b0, reset = 1'b0, arb_en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [5*N-1:0]  req_addr = '0;
    logic [DW*N-1:0] req_data = '0;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [DW-1:0]   wr_data;
    logic [4:0]      rd_addr_1 = '0, rd_addr_2 = '0;
    logic [DW-1:0]   gpr_data_1 = '0, gpr_data_2 = '0;
    logic [DW-1:0]   rd_data_1, rd_data_2;
    logic [CW-1:0]   conflict_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int            cyc;
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb[$];
    int            order[$];
    int            m_cnt;
    logic          m_wen;
    logic [4:0]    m_waddr;
    logic [DW-1:0] m_wdata;

    logic [4:0] dir_addr [N];
    int         exp_g    [5];

    gpr_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr_1    (rd_addr_1),
        .rd_addr_2    (rd_addr_2),
        .gpr_data_1   (gpr_data_1),
        .gpr_data_2   (gpr_data_2),
        .rd_data_1    (rd_data_1),
        .rd_data_2    (rd_data_2),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: fairness order kept as a list, most recently served requester last.
    always @(negedge clk) begin : model
        int            g;
        logic [N-1:0]  exp_rdy;
        logic [4:0]    a;
        logic [DW-1:0] d;
        wr_t           w;
        if (!reset) begin
            order   = {0, 1, 2, 3};
            m_cnt   = 0;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            sb.delete();
        end
        g = -1;
        if (reset && arb_en)
            foreach (order[k]) if (g < 0 && req_valid[order[k]]) g = order[k];
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        chk("wr_en", wr_en, m_wen);
        chk("wr_addr", wr_addr, m_waddr);
        chk("wr_data", wr_data, m_wdata);
        chk("rd_data_1", rd_data_1,
            (m_wen && m_waddr == rd_addr_1 && rd_addr_1 != 0) ? m_wdata : gpr_data_1);
        chk("rd_data_2", rd_data_2,
            (m_wen && m_waddr == rd_addr_2 && rd_addr_2 != 0) ? m_wdata : gpr_data_2);
        if (reset) begin
            if (arb_en && $countones(req_valid) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
            m_wen = 1'b0;
            if (g >= 0) begin
                while (order[$] != g) order.push_back(order.pop_front());
                a = req_addr[g*5 +: 5];
                d = req_data[g*DW +: DW];
                if (a != 0) begin
                    m_wen   = 1'b1;
                    m_waddr = a;
                    m_wdata = d;
                    w.cyc   = cyc + 1;
                    w.addr  = a;
                    w.data  = d;
                    sb.push_back(w);
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        if (wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: write addr %0d data %0h, none expected (cycle %0d)",
                         wr_addr, wr_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("sb_cycle", cyc, e.cyc);
                chk("sb_addr", wr_addr, e.addr);
                chk("sb_data", wr_data, e.data);
            end
        end else if (reset && sb.size() > 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL sb_missing: no write, expected addr %0d in cycle %0d (cycle %0d)",
                     sb[0].addr, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_addr[i*5 +: 5]  = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic drain();
        logic [N-1:0] hs;
        for (int n = 0; n < 20 && req_valid != '0; n++) begin
            #2;
            hs = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~hs;
        end
        chk("drain_done", req_valid, '0);
    endtask

    function automatic logic [4:0] pick_addr();
        logic [4:0] tbl [6];
        tbl = '{5'd0, 5'd1, 5'd2, 5'd5, REG_FLAG, REG_RA};
        if ($urandom_range(0, 3) == 0) return 5'($urandom());
        return tbl[$urandom_range(0, 5)];
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_addr = '{5'd1, 5'd2, REG_FLAG, REG_RA};
        exp_g    = '{int'(REQ_WB), int'(REQ_LINK), int'(REQ_FLAG), int'(REQ_MDU), int'(REQ_WB)};
        arb_en   = 1'b1;
        req_valid = 4'b0101;
        repeat (3) tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cnt", conflict_cnt, 0);
        req_valid = '0;
        reset = 1'b1;
        tick();

        // All four requesters continuously valid from a fresh pointer.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, dir_addr[i], 32'hD000_0000 + i);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("grant_order", req_ready, 1 << exp_g[k]);
            chk("cnt_step", conflict_cnt, k);
            if (k > 0) chk("wr_addr_seq", wr_addr, dir_addr[exp_g[k-1]]);
            tick();
        end
        chk("wr_addr_seq", wr_addr, dir_addr[exp_g[4]]);
        req_valid[0] = 1'b0;
        drain();

        // Single request latency.
        set_req(0, 1'b1, 5'd8, 32'h1234_5678);
        #1 chk("single_ready", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        chk("single_wr_en", wr_en, 1);
        chk("single_wr_addr", wr_addr, 8);
        chk("single_wr_data", wr_data, 32'h1234_5678);
        tick();
        chk("single_wr_en_off", wr_en, 0);

        // Write to $0 completes the handshake but never reaches the port.
        set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        rd_addr_1  = 5'd0;
        gpr_data_1 = 32'h1357_9BDF;
        #1 chk("zero_ready", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        chk("zero_wr_en", wr_en, 0);
        chk("zero_rd_data", rd_data_1, 32'h1357_9BDF);
        set_req(1, 1'b1, 5'd3, 32'h11);
        set_req(2, 1'b1, 5'd4, 32'h22);
        #1 chk("zero_ptr_adv", req_ready, 4'b0100);
        drain();

        // Forwarding of the in-flight write.
        set_req(3, 1'b1, REG_RA, 32'h0040_0010);
        tick();
        req_valid[3] = 1'b0;
        rd_addr_2  = REG_RA;
        gpr_data_2 = '0;
        #1 chk("fwd_hit", rd_data_2, 32'h0040_0010);
        rd_addr_2  = REG_FLAG;
        gpr_data_2 = 32'hCAFE_F00D;
        #1 chk("fwd_miss", rd_data_2, 32'hCAFE_F00D);
        tick();

        // Arbitration disabled holds off grants; enabling grants in the same cycle.
        arb_en = 1'b0;
        set_req(2, 1'b1, 5'd7, 32'h77);
        repeat (5) begin
            #1;
            chk("dis_ready", req_ready, 0);
            chk("dis_wr_en", wr_en, 0);
            tick();
        end
        arb_en = 1'b1;
        #1 chk("en_ready", req_ready, 4'b0100);
        tick();
        req_valid[2] = 1'b0;

        // Counter saturation.
        set_req(0, 1'b1, 5'd9, 32'h99);
        set_req(1, 1'b1, 5'd10, 32'hAA);
        repeat (10) tick();
        chk("cnt_sat", conflict_cnt, (1 << CW) - 1);
        drain();
        tick();

        // Reset while a write is registered discards it.
        set_req(0, 1'b1, 5'd5, 32'hAAAA_0005);
        tick();
        req_valid[0] = 1'b0;
        chk("pre_rst_wr_en", wr_en, 1);
        reset = 1'b0;
        #1 chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_wr_addr", wr_addr, 0);
        tick();
        tick();
        reset      = 1'b1;
        rd_addr_1  = 5'd5;
        gpr_data_1 = 32'h0000_1234;
        #1 chk("post_rst_rd", rd_data_1, 32'h0000_1234);
        chk("post_rst_cnt", conflict_cnt, 0);
        tick();

        // Randomized traffic under the protocol rules.
        for (int n = 0; n < 1500; n++) begin
            logic [N-1:0] hs;
            #2;
            hs = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    if ($urandom_range(0, 99) < 45) set_req(i, 1'b1, pick_addr(), $urandom());
                    else req_valid[i] = 1'b0;
                end
            end
            arb_en     = ($urandom_range(0, 9) != 0);
            rd_addr_1  = pick_addr();
            rd_addr_2  = pick_addr();
            gpr_data_1 = $urandom();
            gpr_data_2 = $urandom();
        end
        arb_en = 1'b1;
        drain();
        repeat (2) tick();
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
